// File: rtl/encoder_seg_pkg.sv
// Shared constants for the encoder display path: seven-segment glyphs
// (active-low, dp in bit 7) and digit-enable codes.
package encoder_seg_pkg;

    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_OFF  = 8'hFF;

    localparam logic [1:0] AN_OFF = 2'b11;
    localparam logic [1:0] AN_D0  = 2'b10;
    localparam logic [1:0] AN_D1  = 2'b01;

    typedef enum logic {
        DIG0 = 1'b0,
        DIG1 = 1'b1
    } dig_sel_e;

endpackage

// File: rtl/encoder_seg_hex_decoder.sv
// Combinational nibble-to-glyph lookup for an active-low seven-segment digit.
module seg_hex_decoder
    import encoder_seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    // glyph table lookup
    always_comb begin
        seg = SEG_HEX[nib];
    end

endmodule

// File: rtl/encoder_seg_disp.sv
// Deglitches the priority-encoder result, counts accepted changes and drives
// a two-digit multiplexed seven-segment display (index / change-count nibble).
module encoder_seg_disp
    import encoder_seg_pkg::*;
#(
    parameter int CLK_DIV    = 50000,
    parameter int STABLE_CYC = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_num,
    output logic       o_valid,
    output logic [2:0] o_idx,
    output logic       o_chg,
    output logic [7:0] o_chg_cnt,
    output logic [7:0] o_seg,
    output logic [1:0] o_an
);

    localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    logic [3:0]    sample_r;
    logic [3:0]    cand_r;
    logic [3:0]    held_r;
    logic [CW-1:0] stab_cnt_r;
    logic [DW-1:0] div_r;
    dig_sel_e      sel_r;

    logic          accept_s;
    logic          tick_s;
    logic [3:0]    dec_nib_s;
    logic [7:0]    glyph_s;
    logic [7:0]    seg_next_s;
    logic [1:0]    an_next_s;

    assign o_valid = held_r[3];
    assign o_idx   = held_r[2:0];

    // accept only a candidate that has been stable long enough and differs from the held value
    always_comb begin
        accept_s = (sample_r == cand_r) && (stab_cnt_r == CNT_MAX) && (cand_r != held_r);
        tick_s   = (div_r == DIV_MAX);
    end

    // input sample, candidate tracking and stability counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sample_r   <= 4'h0;
            cand_r     <= 4'h0;
            stab_cnt_r <= '0;
        end else begin
            sample_r <= i_num;
            if (sample_r != cand_r) begin
                cand_r     <= sample_r;
                stab_cnt_r <= '0;
            end else if (stab_cnt_r < CNT_MAX) begin
                stab_cnt_r <= stab_cnt_r + CW'(1);
            end else begin
                stab_cnt_r <= stab_cnt_r;
            end
        end
    end

    // held value, change pulse and wrapping change counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            held_r    <= 4'h0;
            o_chg     <= 1'b0;
            o_chg_cnt <= 8'd0;
        end else if (accept_s) begin
            held_r    <= cand_r;
            o_chg     <= 1'b1;
            o_chg_cnt <= o_chg_cnt + 8'd1;
        end else begin
            o_chg <= 1'b0;
        end
    end

    // refresh divider; each wrap flips the active digit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_r <= '0;
            sel_r <= DIG0;
        end else if (tick_s) begin
            div_r <= '0;
            sel_r <= (sel_r == DIG0) ? DIG1 : DIG0;
        end else begin
            div_r <= div_r + DW'(1);
        end
    end

    // single decoder shared by both digits
    always_comb begin
        case (sel_r)
            DIG0:    dec_nib_s = {1'b0, held_r[2:0]};
            DIG1:    dec_nib_s = o_chg_cnt[3:0];
            default: dec_nib_s = 4'h0;
        endcase
    end

    seg_hex_decoder u_dec (
        .nib (dec_nib_s),
        .seg (glyph_s)
    );

    // next display drive; digit 0 shows a dash while nothing is valid
    always_comb begin
        case (sel_r)
            DIG0: begin
                an_next_s  = AN_D0;
                seg_next_s = held_r[3] ? glyph_s : SEG_DASH;
            end
            DIG1: begin
                an_next_s  = AN_D1;
                seg_next_s = glyph_s;
            end
            default: begin
                an_next_s  = AN_OFF;
                seg_next_s = SEG_OFF;
            end
        endcase
    end

    // display output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_seg <= SEG_OFF;
            o_an  <= AN_OFF;
        end else begin
            o_seg <= seg_next_s;
            o_an  <= an_next_s;
        end
    end

endmodule

// File: tb/tb_encoder_seg_disp.sv
// Directed self-checking bench for encoder_seg_disp with CLK_DIV=4, STABLE_CYC=4.
module tb_encoder_seg_disp;

    logic       clk;
    logic       rst;
    logic [3:0] num;
    logic       valid;
    logic [2:0] idx;
    logic       chg;
    logic [7:0] chg_cnt;
    logic [7:0] seg;
    logic [1:0] an;

    int checks   = 0;
    int failures = 0;
    int ecnt     = 0;
    int pulses   = 0;
    bit dchk     = 1'b0;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;

    encoder_seg_disp #(
        .CLK_DIV    (4),
        .STABLE_CYC (4)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_num     (num),
        .o_valid   (valid),
        .o_idx     (idx),
        .o_chg     (chg),
        .o_chg_cnt (chg_cnt),
        .o_seg     (seg),
        .o_an      (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one edge; sample 1 time unit later; optionally check display against the model
    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
        if (chg === 1'b1) pulses++;
        if (dchk) begin
            if ((((ecnt - 1) / 4) % 2) == 0) begin
                chk("an_d0", {30'd0, an}, 32'h2);
                chk("seg_d0", {24'd0, seg}, {24'd0, exp_d0});
            end else begin
                chk("an_d1", {30'd0, an}, 32'h1);
                chk("seg_d1", {24'd0, seg}, {24'd0, exp_d1});
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_idx"}, {29'd0, idx}, 32'd0);
        chk({tag, "_chg"}, {31'd0, chg}, 32'd0);
        chk({tag, "_cnt"}, {24'd0, chg_cnt}, 32'd0);
        chk({tag, "_seg"}, {24'd0, seg}, 32'hFF);
        chk({tag, "_an"}, {30'd0, an}, 32'h3);
    endtask

    initial begin
        rst = 1'b0;
        num = 4'h0;
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_imm");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        ecnt = 0;

        // idle display: dash on digit 0, count 0 on digit 1
        exp_d0 = 8'hBF;
        exp_d1 = 8'hC0;
        dchk = 1'b1;
        repeat (16) tick();
        dchk = 1'b0;

        // accept 4'hD: edge 6 after the first sampling edge
        num = 4'hD;
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("acc_pre_chg", {31'd0, chg}, 32'd0);
            chk("acc_pre_valid", {31'd0, valid}, 32'd0);
        end
        tick();
        chk("acc_chg", {31'd0, chg}, 32'd1);
        chk("acc_valid", {31'd0, valid}, 32'd1);
        chk("acc_idx", {29'd0, idx}, 32'd5);
        chk("acc_cnt", {24'd0, chg_cnt}, 32'd1);
        tick();
        chk("acc_chg_1cyc", {31'd0, chg}, 32'd0);
        exp_d0 = 8'h92;
        exp_d1 = 8'hF9;
        dchk = 1'b1;
        repeat (8) tick();

        // glitch of 3 cycles then return to held value
        pulses = 0;
        num = 4'hA;
        repeat (3) tick();
        num = 4'hD;
        repeat (10) tick();
        dchk = 1'b0;
        chk("glitch_pulses", pulses, 32'd0);
        chk("glitch_cnt", {24'd0, chg_cnt}, 32'd1);
        chk("glitch_idx", {29'd0, idx}, 32'd5);

        // chatter F/E then settle on E
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            num = (i % 2 == 1) ? 4'hE : 4'hF;
            tick();
        end
        chk("chat_pulses", pulses, 32'd0);
        repeat (4) tick();
        chk("chat_pre_chg", {31'd0, chg}, 32'd0);
        tick();
        chk("chat_chg", {31'd0, chg}, 32'd1);
        chk("chat_idx", {29'd0, idx}, 32'd6);
        chk("chat_cnt", {24'd0, chg_cnt}, 32'd2);
        chk("chat_pulses_one", pulses, 32'd1);
        tick();
        exp_d0 = 8'h82;
        exp_d1 = 8'hA4;
        dchk = 1'b1;
        repeat (8) tick();
        dchk = 1'b0;

        // counter wrap: 254 more accepts take the count from 2 back to 0
        pulses = 0;
        for (int k = 1; k <= 254; k++) begin
            num = (k % 2 == 1) ? 4'h9 : 4'hA;
            repeat (6) tick();
            if (k == 14) begin
                chk("cnt16", {24'd0, chg_cnt}, 32'd16);
                tick();
                exp_d0 = 8'hA4;
                exp_d1 = 8'hC0;
                dchk = 1'b1;
                repeat (8) tick();
                dchk = 1'b0;
            end
        end
        chk("wrap_pulses", pulses, 32'd254);
        chk("wrap_cnt", {24'd0, chg_cnt}, 32'd0);
        tick();
        exp_d0 = 8'hA4;
        exp_d1 = 8'hC0;
        dchk = 1'b1;
        repeat (8) tick();
        dchk = 1'b0;

        // async reset while the filter counter is part-way
        num = 4'hB;
        repeat (4) tick();
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        rst = 1'b0;
        ecnt = 0;
        pulses = 0;
        tick();
        chk("rel_an", {30'd0, an}, 32'h2);
        chk("rel_seg", {24'd0, seg}, 32'hBF);
        chk("rel_valid1", {31'd0, valid}, 32'd0);
        repeat (4) tick();
        chk("rel_pre_valid", {31'd0, valid}, 32'd0);
        tick();
        chk("rel_valid", {31'd0, valid}, 32'd1);
        chk("rel_idx", {29'd0, idx}, 32'd3);
        chk("rel_chg", {31'd0, chg}, 32'd1);
        chk("rel_cnt", {24'd0, chg_cnt}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_seg_disp.md
Name: encoder_seg_disp

Overview:
- Downstream consumer of the 8-to-4 priority encoder.
- Takes the encoder's {valid, idx[2:0]} result and deglitches it with a stability filter.
- Counts accepted changes and drives a 2-digit multiplexed seven-segment display.
- Digit 0 shows the active index (or a dash when no input is active). Digit 1 shows the low nibble of the change count.

Parameters:
- CLK_DIV, 50000: clock cycles per digit refresh slot. Legal range ≥2.
- STABLE_CYC, 4: consecutive cycles a sampled value must hold before it is accepted. Legal range ≥1.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_num  input  4  encoder result: [3] = valid, [2:0] = index. Same clock domain.
- o_valid  output  1  accepted valid bit.
- o_idx  output  3  accepted index.
- o_chg  output  1  one-cycle pulse on each accepted change.
- o_chg_cnt  output  8  count of accepted changes. Wraps 255→0.
- o_seg  output  8  segments, active-low. Bit 0 = a … bit 6 = g, bit 7 = dp.
- o_an  output  2  digit enables, active-low. Bit 0 = digit 0.

Behaviour:
- Reset (async, immediate, no clock needed):
  - all registers cleared
  - o_valid=0, o_idx=0, o_chg=0, o_chg_cnt=0
  - o_seg=8'hFF, o_an=2'b11
  - internal sample/candidate/held=4'h0, stability counter=0, divider=0, digit select=0
- Sample stage: r_sample <= i_num every cycle.
- Stability filter, per edge:
  - r_sample != r_cand: r_cand <= r_sample, cnt <= 0.
  - else, cnt < STABLE_CYC-1: cnt increments.
  - Accept condition: r_sample == r_cand, cnt == STABLE_CYC-1, and r_cand != r_held.
    - r_held <= r_cand
    - o_chg <= 1
    - o_chg_cnt <= o_chg_cnt+1, modulo 256
  - cnt saturates at STABLE_CYC-1. No re-accept while r_held == r_cand.
- Latency:
  - Count edge 1 as the edge that first samples a new steady i_num.
  - o_valid/o_idx/o_chg update at edge STABLE_CYC+2 (edge 6 at default).
  - o_chg is high for exactly one cycle per accept.
- Deglitch boundaries:
  - Any value shorter than STABLE_CYC+1 samples is never accepted.
  - If i_num returns to the held value before acceptance, nothing happens: no pulse, no count.
  - Continuous chatter produces no accept until the input settles.
- Divider:
  - Counts 0..CLK_DIV-1. Tick on wrap.
  - Each tick toggles the digit select.
- Display registers (o_seg/o_an), updated every edge from the current select and the pre-edge held/count values:
  - sel=0:
    - o_an=2'b10
    - o_seg = hex glyph of held idx if held valid, else dash (8'hBF)
  - sel=1:
    - o_an=2'b01
    - o_seg = hex glyph of o_chg_cnt[3:0]
  - dp is always off (1).
- Glyphs, 0..F:
  - 0 = C0, 1 = F9, 2 = A4, 3 = B0
  - 4 = 99, 5 = 92, 6 = 82, 7 = F8
  - 8 = 80, 9 = 90, A = 88, b = 83
  - C = C6, d = A1, E = 86, F = 8E
- Simultaneous accept and tick: both take effect. The new glyph appears one cycle after the held update.
- Display timing after reset release:
  - First edge: o_an=2'b10, o_seg=8'hBF.
  - The digit switches every CLK_DIV cycles.
- Reset mid-filter: any pending candidate is discarded. A steady input is re-accepted STABLE_CYC+2 edges after release.

Decomposition:
- Package encoder_seg_pkg:
  - glyph constants SEG_HEX[0:15], SEG_DASH=8'hBF, SEG_OFF=8'hFF
  - AN_OFF=2'b11, AN_D0=2'b10, AN_D1=2'b01
- Sub-module seg_hex_decoder: combinational 4-bit→8-bit glyph lookup, one instance, muxed input.
- Top holds:
  - sample/filter registers
  - change counter
  - refresh divider
  - digit select
  - output registers

Test Plan (CLK_DIV=4, STABLE_CYC=4):
- Reset: i_rst=1 mid-cycle → all outputs at reset values immediately. Release with i_num=0 → o_an alternates 2'b10/2'b01 every 4 cycles; o_seg alternates 8'hBF/8'hC0.
- Accept: i_num 4'h0→4'hD held → o_valid=1, o_idx=5 at edge 6; o_chg one-cycle pulse; o_chg_cnt=1. Digit 0 shows 8'h92, digit 1 shows 8'hF9.
- Glitch reject: held 4'hD; drive 4'hA for 3 cycles, then back to 4'hD → no o_chg, o_chg_cnt stays 1, o_idx stays 5.
- Chatter: alternate 4'hF/4'hE every cycle for 20 cycles, then hold 4'hE → exactly one accept, 6 edges after settling. o_idx=6, o_chg_cnt=2.
- Wrap: 256 accepted changes alternating 4'h9/4'hA → o_chg_cnt returns to 0, digit 1 glyph 8'hC0. At count 16, digit 1 also shows 8'hC0.
- Async reset mid-filter: assert i_rst between edges while cnt=2 → outputs clear without a clock edge. After release with i_num=4'hB steady → o_valid=1, o_idx=3 at edge 6.
